// File: rtl/rv_regfile_param.sv
// Parameterized RISC-V integer register file: registered multi-port reads with
// same-cycle write bypass, and a per-register busy scoreboard.
module rv_regfile_param #(
  parameter int          XLEN     = 32,
  parameter int          NREGS    = 32,
  parameter int          NRD      = 2,
  parameter int          NWR      = 1,
  parameter logic [63:0] SP_RESET = 64'd4096,
  localparam int         AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr
);

  // Read-side views include x0 as a constant so indexing needs no range guard.
  logic [XLEN-1:0] rf_view   [NREGS];
  logic            busy_view [NREGS];

  assign rf_view[0]   = '0;
  assign busy_view[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    localparam logic [XLEN-1:0] RST_VAL = (r == 2) ? SP_RESET[XLEN-1:0] : '0;
    logic [XLEN-1:0] q;
    logic            b;

    // Later write ports override earlier ones; a set overrides a clearing write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= RST_VAL;
        b <= 1'b0;
      end else begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && (wr_addr[k*AW +: AW] == AW'(r))) begin
            q <= wr_data[k*XLEN +: XLEN];
            b <= 1'b0;
          end
        end
        if (sb_set && (sb_addr == AW'(r))) begin
          b <= 1'b1;
        end
      end
    end

    assign rf_view[r]   = q;
    assign busy_view[r] = b;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] data_nxt;
    logic            busy_nxt;
    logic [XLEN-1:0] data_q;
    logic            busy_q;

    assign idx = rd_addr[i*AW +: AW];

    // Busy reported after same-cycle clears, before same-cycle sets.
    always_comb begin
      data_nxt = rf_view[idx];
      busy_nxt = busy_view[idx];
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && (idx != '0) && (wr_addr[k*AW +: AW] == idx)) begin
          data_nxt = wr_data[k*XLEN +: XLEN];
          busy_nxt = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_nxt;
        busy_q <= busy_nxt;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data_q;
    assign rd_busy[i]              = busy_q;
  end

endmodule
